// File: rtl/clint_timer_unit_if.sv
// Register port of the CLINT: single-cycle read/write requests with byte
// strobes, plus the registered read response.
interface clint_timer_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    reg_wen;
    logic                    reg_ren;
    logic [15:0]             reg_addr;
    logic [DATA_WIDTH-1:0]   reg_wdata;
    logic [DATA_WIDTH/8-1:0] reg_wstrb;
    logic [DATA_WIDTH-1:0]   reg_rdata;
    logic                    reg_rvalid;

    modport master (
        output reg_wen, reg_ren, reg_addr, reg_wdata, reg_wstrb,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_wen, reg_ren, reg_addr, reg_wdata, reg_wstrb,
        output reg_rdata, reg_rvalid
    );
endinterface

// File: rtl/clint_timer_unit.sv
// CLINT timer unit: prescaled 64-bit mtime, per-hart mtimecmp/msip and
// registered mtip, behind a 32- or 64-bit register port.
module clint_timer_unit #(
    parameter int unsigned HART_NUM     = 1,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TICK_DIV     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clint_timer_unit_if.slave    bus,
    output logic [63:0]          mtime,
    output logic [HART_NUM-1:0]  mtip,
    output logic [HART_NUM-1:0]  msip
);
    logic [15:0]         pre_cnt;
    logic                tick;
    logic [7:0]          strb8;
    logic [63:0]         wdata_ext;
    logic [63:0]         wmask_ext;
    logic [63:0]         wdata64;
    logic [63:0]         wmask64;
    logic                hi_lane;
    logic                msip_lane_hi;
    logic                word_ok;
    logic                mtime_hit;
    logic                msip_wval;
    logic                msip_wen;
    logic [HART_NUM-1:0] msip_sel;
    logic [HART_NUM-1:0] cmp_sel;
    logic [63:0]         mtimecmp [HART_NUM];
    logic [63:0]         rd64;
    logic [63:0]         rd_msip;
    logic [63:0]         rd_word;
    logic                unused_addr;

    assign unused_addr  = ^bus.reg_addr[1:0];
    assign tick         = (pre_cnt == 16'(TICK_DIV - 1));
    assign strb8        = 8'(bus.reg_wstrb);
    assign wdata_ext    = 64'(bus.reg_wdata);

    // 32-bit port: addr[2] steers the word onto the upper half of a 64-bit register.
    assign hi_lane      = (DATA_WIDTH == 32) && bus.reg_addr[2];
    assign msip_lane_hi = (DATA_WIDTH == 64) && bus.reg_addr[2];
    assign word_ok      = (DATA_WIDTH == 32) || !bus.reg_addr[2];
    assign mtime_hit    = (bus.reg_addr[15:3] == 13'h17FF) && word_ok;

    for (genvar b = 0; b < 8; b++) begin : g_mask
        assign wmask_ext[b*8 +: 8] = {8{strb8[b]}};
    end

    assign wdata64   = hi_lane ? {wdata_ext[31:0], 32'h0} : wdata_ext;
    assign wmask64   = hi_lane ? {wmask_ext[31:0], 32'h0} : wmask_ext;
    assign msip_wval = msip_lane_hi ? wdata_ext[32] : wdata_ext[0];
    assign msip_wen  = msip_lane_hi ? wmask_ext[32] : wmask_ext[0];

    always_comb begin
        msip_sel = '0;
        cmp_sel  = '0;
        rd64     = mtime_hit ? mtime : '0;
        rd_msip  = '0;
        for (int unsigned h = 0; h < HART_NUM; h++) begin
            msip_sel[h] = (bus.reg_addr[15:2] == 14'(h));
            cmp_sel[h]  = (bus.reg_addr[15:14] == 2'b01) &&
                          (bus.reg_addr[13:3] == 11'(h)) && word_ok;
            if (cmp_sel[h]) begin
                rd64 = rd64 | mtimecmp[h];
            end
            if (msip_sel[h] && msip[h]) begin
                rd_msip = msip_lane_hi ? 64'h0000_0001_0000_0000 : 64'h1;
            end
        end
        rd_word = (hi_lane ? {32'h0, rd64[63:32]} : rd64) | rd_msip;
    end

    // A write to mtime wins over the tick; the prescaler is left running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            mtime   <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
            if (bus.reg_wen && mtime_hit) begin
                mtime <= (mtime & ~wmask64) | (wdata64 & wmask64);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msip <= '0;
            mtip <= '0;
            for (int unsigned h = 0; h < HART_NUM; h++) begin
                mtimecmp[h] <= MTIMECMP_RST;
            end
        end else begin
            for (int unsigned h = 0; h < HART_NUM; h++) begin
                if (bus.reg_wen && cmp_sel[h]) begin
                    mtimecmp[h] <= (mtimecmp[h] & ~wmask64) | (wdata64 & wmask64);
                end
                if (bus.reg_wen && msip_sel[h] && msip_wen) begin
                    msip[h] <= msip_wval;
                end
                mtip[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.reg_rdata  <= '0;
            bus.reg_rvalid <= 1'b0;
        end else begin
            bus.reg_rvalid <= bus.reg_ren;
            if (bus.reg_ren) begin
                bus.reg_rdata <= rd_word[DATA_WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_clint_timer_unit.sv
// Directed bench for clint_timer_unit: a 32-bit/TICK_DIV=1 and a
// 64-bit/TICK_DIV=4 instance, both with two harts; reads go through a scoreboard.
module tb_clint_timer_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clint_timer_unit_if #(.DATA_WIDTH(32)) b32 ();
    clint_timer_unit_if #(.DATA_WIDTH(64)) b64 ();

    logic [63:0] mtime32, mtime64;
    logic [1:0]  mtip32, msip32, mtip64, msip64;

    clint_timer_unit #(.HART_NUM(2), .DATA_WIDTH(32), .TICK_DIV(1)) u32 (
        .clk(clk), .rst_n(rst_n), .bus(b32),
        .mtime(mtime32), .mtip(mtip32), .msip(msip32)
    );

    clint_timer_unit #(.HART_NUM(2), .DATA_WIDTH(64), .TICK_DIV(4)) u64 (
        .clk(clk), .rst_n(rst_n), .bus(b64),
        .mtime(mtime64), .mtip(mtip64), .msip(msip64)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [63:0] q32[$];
    logic [63:0] q64[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read responses are popped from the scoreboard on the opposite edge.
    always @(negedge clk) begin
        if (b32.reg_rvalid === 1'b1) begin
            if (q32.size() == 0) chk("rd32_unexpected", {63'b0, b32.reg_rvalid}, 64'd0);
            else chk("rd32_data", 64'(b32.reg_rdata), q32.pop_front());
        end
        if (b64.reg_rvalid === 1'b1) begin
            if (q64.size() == 0) chk("rd64_unexpected", {63'b0, b64.reg_rvalid}, 64'd0);
            else chk("rd64_data", b64.reg_rdata, q64.pop_front());
        end
    end

    task automatic acc32(input logic w, input logic r, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
        b32.reg_wen = w; b32.reg_ren = r; b32.reg_addr = a;
        b32.reg_wdata = d; b32.reg_wstrb = s;
        if (r) q32.push_back(64'(exp));
        tick();
        chk("rvalid32", {63'b0, b32.reg_rvalid}, {63'b0, r});
        b32.reg_wen = 1'b0; b32.reg_ren = 1'b0;
    endtask

    task automatic acc64(input logic w, input logic r, input logic [15:0] a,
                         input logic [63:0] d, input logic [7:0] s, input logic [63:0] exp);
        b64.reg_wen = w; b64.reg_ren = r; b64.reg_addr = a;
        b64.reg_wdata = d; b64.reg_wstrb = s;
        if (r) q64.push_back(exp);
        tick();
        chk("rvalid64", {63'b0, b64.reg_rvalid}, {63'b0, r});
        b64.reg_wen = 1'b0; b64.reg_ren = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] em;
        logic [63:0] prev;
        b32.reg_wen = 1'b0; b32.reg_ren = 1'b0; b32.reg_addr = '0;
        b32.reg_wdata = '0; b32.reg_wstrb = '0;
        b64.reg_wen = 1'b0; b64.reg_ren = 1'b0; b64.reg_addr = '0;
        b64.reg_wdata = '0; b64.reg_wstrb = '0;
        repeat (3) tick();

        chk("rst_mtime32", mtime32, 64'd0);
        chk("rst_mtime64", mtime64, 64'd0);
        chk("rst_mtip32", 64'(mtip32), 64'd0);
        chk("rst_msip32", 64'(msip32), 64'd0);
        chk("rst_mtip64", 64'(mtip64), 64'd0);
        chk("rst_msip64", 64'(msip64), 64'd0);
        chk("rst_rvalid32", {63'b0, b32.reg_rvalid}, 64'd0);
        chk("rst_rdata32", 64'(b32.reg_rdata), 64'd0);
        chk("rst_rvalid64", {63'b0, b64.reg_rvalid}, 64'd0);
        chk("rst_rdata64", b64.reg_rdata, 64'd0);
        rst_n = 1'b1;

        // Edge k after reset: 32-bit mtime = k, 64-bit (TICK_DIV=4) mtime = k/4.
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("presc32", mtime32, 64'(k));
            chk("presc64", mtime64, 64'(k / 4));
        end

        repeat (3) tick();
        chk("m64_pre_wr", mtime64, 64'd5);
        acc64(1'b1, 1'b0, 16'hBFF8, 64'h0000_0001_0000_0000, 8'hF0, '0);
        chk("m64_hi_wr", mtime64, 64'h0000_0001_0000_0005);
        repeat (3) tick();
        chk("m64_hold", mtime64, 64'h0000_0001_0000_0005);
        tick();
        chk("m64_next_tick", mtime64, 64'h0000_0001_0000_0006);
        acc64(1'b1, 1'b0, 16'h4004, '0, 8'hFF, '0);
        acc64(1'b0, 1'b1, 16'h4000, '0, '0, 64'hFFFF_FFFF_FFFF_FFFF);
        acc64(1'b0, 1'b1, 16'hBFF8, '0, '0, 64'h0000_0001_0000_0006);
        acc64(1'b0, 1'b1, 16'hBFFC, '0, '0, 64'd0);
        acc64(1'b1, 1'b0, 16'h0004, 64'h0000_0001_0000_0000, 8'h10, '0);
        chk("msip64_lane_hi", 64'(msip64), 64'd2);
        acc64(1'b1, 1'b0, 16'h0000, 64'h1, 8'hFE, '0);
        chk("msip64_wrong_strb", 64'(msip64), 64'd2);
        acc64(1'b0, 1'b1, 16'h0004, '0, '0, 64'h0000_0001_0000_0000);
        acc64(1'b0, 1'b1, 16'h0000, '0, '0, 64'd0);
        chk("mtip64_idle", 64'(mtip64), 64'd0);

        acc32(1'b0, 1'b1, 16'h4000, '0, '0, 32'hFFFF_FFFF);
        acc32(1'b0, 1'b1, 16'h4004, '0, '0, 32'hFFFF_FFFF);

        acc32(1'b1, 1'b0, 16'hBFF8, 32'd0, 4'hF, '0);
        em = 64'd0;
        chk("m32_wr0", mtime32, em);
        acc32(1'b1, 1'b0, 16'h4008, 32'd10, 4'hF, '0);
        em++;
        acc32(1'b1, 1'b0, 16'h400C, 32'd0, 4'hF, '0);
        em++;
        chk("m32_after_cmp", mtime32, em);
        chk("mtip32_after_cmp", 64'(mtip32), 64'd0);
        for (int i = 0; i < 12; i++) begin
            prev = em;
            tick();
            em++;
            chk("m32_run", mtime32, em);
            chk("mtip32_rise", 64'(mtip32), (prev >= 64'd10) ? 64'd2 : 64'd0);
        end
        acc32(1'b0, 1'b1, 16'h4008, '0, '0, 32'd10);
        acc32(1'b0, 1'b1, 16'h400C, '0, '0, 32'd0);
        acc32(1'b0, 1'b1, 16'h4010, '0, '0, 32'd0);

        acc32(1'b1, 1'b0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, '0);
        acc32(1'b1, 1'b0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, '0);
        chk("m32_all_ones", mtime32, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("m32_wrap", mtime32, 64'd0);
        chk("mtip32_at_max", 64'(mtip32), 64'd3);
        tick();
        chk("m32_after_wrap", mtime32, 64'd1);
        chk("mtip32_drop", 64'(mtip32), 64'd0);

        acc32(1'b1, 1'b0, 16'h0000, 32'd1, 4'h2, '0);
        chk("msip32_wrong_strb", 64'(msip32), 64'd0);
        acc32(1'b1, 1'b0, 16'h0000, 32'd1, 4'h1, '0);
        chk("msip32_set0", 64'(msip32), 64'd1);
        acc32(1'b0, 1'b1, 16'h0000, '0, '0, 32'd1);
        acc32(1'b0, 1'b1, 16'h0100, '0, '0, 32'd0);
        acc32(1'b1, 1'b0, 16'h0004, 32'd1, 4'h1, '0);
        chk("msip32_set1", 64'(msip32), 64'd3);
        acc32(1'b1, 1'b1, 16'h0000, 32'd0, 4'h1, 32'd1);
        chk("msip32_clr0", 64'(msip32), 64'd2);
        acc32(1'b0, 1'b1, 16'h0000, '0, '0, 32'd0);
        acc32(1'b0, 1'b1, 16'h0004, '0, '0, 32'd1);

        // Read issued on a reset edge must never produce a response.
        b32.reg_ren = 1'b1;
        b32.reg_addr = 16'h0004;
        rst_n = 1'b0;
        tick();
        b32.reg_ren = 1'b0;
        chk("midrst_rvalid", {63'b0, b32.reg_rvalid}, 64'd0);
        chk("midrst_mtime32", mtime32, 64'd0);
        chk("midrst_msip32", 64'(msip32), 64'd0);
        chk("midrst_mtime64", mtime64, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rvalid", {63'b0, b32.reg_rvalid}, 64'd0);

        @(negedge clk);
        #1;
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q64_drained", 64'(q64.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
